beep_sequencer: RTL and testbench

BEEP_SEQUENCER -- requirements
Module: beep_sequencer

---
 rtl/beep_pkg.sv | 18 +
 rtl/beep_song_rom.sv | 15 +
 rtl/beep_sequencer.sv | 105 ++++++++++
 tb/tb_beep_sequencer.sv | 101 ++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// beep_pkg: shared tone codes, song length and FSM state encoding for the beep sequencer.
package beep_pkg;
   localparam logic [7:0] SILENT = 8'h70;
   localparam logic [7:0] TONE_1 = 8'h69;
   localparam logic [7:0] TONE_2 = 8'h72;
   localparam logic [7:0] TONE_3 = 8'h7A;
   localparam logic [7:0] TONE_4 = 8'h6B;
   localparam logic [7:0] TONE_5 = 8'h73;
   localparam logic [7:0] TONE_6 = 8'h74;
   localparam logic [7:0] TONE_7 = 8'h6C;
   localparam logic [7:0] TONE_8 = 8'h75;
   localparam logic [7:0] TONE_9 = 8'h7D;
   localparam int SONG_LEN = 16;
   typedef enum logic [1:0] {IDLE, LIVE, PLAY_NOTE, PLAY_GAP} state_t;
   function automatic logic is_tone(input logic [7:0] c);
      return c inside {TONE_1, TONE_2, TONE_3, TONE_4, TONE_5, TONE_6, TONE_7, TONE_8, TONE_9};
   endfunction
endpackage

// File: rtl/beep_song_rom.sv
// beep_song_rom: combinational 16-entry song table.
//   i_idx  in  4  note index
//   o_code out 8  tone code for that note (SILENT would be a timed rest)
module beep_song_rom
   import beep_pkg::*;
(
   input  logic [3:0] i_idx,
   output logic [7:0] o_code
);
   localparam logic [7:0] SONG [SONG_LEN] = '{
      TONE_1, TONE_2, TONE_3, TONE_4, TONE_5, TONE_6, TONE_7, TONE_8,
      TONE_9, TONE_8, TONE_7, TONE_6, TONE_5, TONE_4, TONE_3, TONE_2
   };
   assign o_code = SONG[i_idx];
endmodule

// File: rtl/beep_sequencer.sv
// beep_sequencer: drives a beeper tone code from live key presses or a built-in timed song.
//   CLK_20M    in   1  system clock
//   RST_N      in   1  asynchronous active-low reset
//   KEY_CODE   in   8  PS/2 scan code
//   KEY_VALID  in   1  strobe qualifying KEY_CODE / KEY_BREAK
//   KEY_BREAK  in   1  strobed code is a release
//   PLAY_START in   1  start the built-in song
//   PLAY_STOP  in   1  abort the song
//   TONE_CODE  out  8  registered tone code, 8'h70 = silence
//   BUSY       out  1  song playing
//   SONG_DONE  out  1  one-cycle pulse on natural song completion
module beep_sequencer
   import beep_pkg::*;
#(
   parameter int TICK_DIV = 20000,
   parameter int NOTE_MS  = 250,
   parameter int GAP_MS   = 20
) (
   input  logic       CLK_20M,
   input  logic       RST_N,
   input  logic [7:0] KEY_CODE,
   input  logic       KEY_VALID,
   input  logic       KEY_BREAK,
   input  logic       PLAY_START,
   input  logic       PLAY_STOP,
   output logic [7:0] TONE_CODE,
   output logic       BUSY,
   output logic       SONG_DONE
);
   localparam int DW = $clog2(TICK_DIV + 1);
   localparam int TW = $clog2((NOTE_MS > GAP_MS ? NOTE_MS : GAP_MS) + 1);
   state_t r_state, w_state;
   logic [7:0] r_tone, w_tone, w_rom;
   logic r_busy, r_done, w_done;
   logic [3:0] r_idx, w_idx, w_rom_idx;
   logic [DW-1:0] r_div, w_div;
   logic [TW-1:0] r_ticks, w_ticks;
   logic w_make, w_release, w_playing, w_div_end, w_phase_end;
   assign w_make      = KEY_VALID && is_tone(KEY_CODE) && !KEY_BREAK;
   assign w_release   = KEY_VALID && KEY_BREAK && KEY_CODE == r_tone;
   assign w_playing   = r_state == PLAY_NOTE || r_state == PLAY_GAP;
   assign w_div_end   = r_div == DW'(TICK_DIV - 1);
   assign w_phase_end = w_div_end && r_ticks == TW'((r_state == PLAY_NOTE ? NOTE_MS : GAP_MS) - 1);
   // In IDLE the rom shows the first note; in a gap it shows the next one.
   assign w_rom_idx   = r_state == PLAY_GAP ? r_idx + 4'd1 : 4'd0;
   beep_song_rom u_rom (.i_idx(w_rom_idx), .o_code(w_rom));
   always_comb begin
      w_state = r_state;
      w_tone  = r_tone;
      w_idx   = r_idx;
      w_done  = 1'b0;
      if (w_make) begin
         w_state = LIVE;
         w_tone  = KEY_CODE;
      end else if (w_playing && PLAY_STOP) begin
         w_state = IDLE;
         w_tone  = SILENT;
      end else if (w_playing && w_phase_end) begin
         if (r_state == PLAY_NOTE) begin
            w_state = PLAY_GAP;
            w_tone  = SILENT;
         end else if (r_idx == 4'(SONG_LEN - 1)) begin
            w_state = IDLE;
            w_tone  = SILENT;
            w_done  = 1'b1;
         end else begin
            w_state = PLAY_NOTE;
            w_idx   = r_idx + 4'd1;
            w_tone  = w_rom;
         end
      end else if (r_state == LIVE && w_release) begin
         w_state = IDLE;
         w_tone  = SILENT;
      end else if (r_state == IDLE && PLAY_START) begin
         w_state = PLAY_NOTE;
         w_idx   = 4'd0;
         w_tone  = w_rom;
      end
      // Counters run only inside a phase and restart on every state change.
      w_div   = (!w_playing || w_state != r_state || w_div_end) ? '0 : r_div + 1'b1;
      w_ticks = (!w_playing || w_state != r_state) ? '0 : w_div_end ? r_ticks + 1'b1 : r_ticks;
   end
   always_ff @(posedge CLK_20M or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_tone  <= SILENT;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_idx   <= '0;
         r_div   <= '0;
         r_ticks <= '0;
      end else begin
         r_state <= w_state;
         r_tone  <= w_tone;
         r_busy  <= w_state == PLAY_NOTE || w_state == PLAY_GAP;
         r_done  <= w_done;
         r_idx   <= w_idx;
         r_div   <= w_div;
         r_ticks <= w_ticks;
      end
   end
   assign TONE_CODE = r_tone;
   assign BUSY      = r_busy;
   assign SONG_DONE = r_done;
endmodule

// File: tb/tb_beep_sequencer.sv
// tb_beep_sequencer: scoreboard bench for beep_sequencer with 12-cycle notes and 4-cycle gaps.
module tb_beep_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [7:0] kc = 8'h00;
   logic kv = 1'b0, kb = 1'b0, ps = 1'b0, pp = 1'b0;
   logic [7:0] tone;
   logic busy, done;
   int n_chk = 0;
   int n_err = 0;
   string tq[$];
   logic [9:0] vq[$];
   logic [7:0] song [16] = '{8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75,
                             8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73, 8'h6B, 8'h7A, 8'h72};
   beep_sequencer #(.TICK_DIV(4), .NOTE_MS(3), .GAP_MS(1)) dut (
      .CLK_20M(clk), .RST_N(rst_n), .KEY_CODE(kc), .KEY_VALID(kv), .KEY_BREAK(kb),
      .PLAY_START(ps), .PLAY_STOP(pp), .TONE_CODE(tone), .BUSY(busy), .SONG_DONE(done)
   );
   always #5 clk = ~clk;
   function automatic logic [9:0] e(input logic [7:0] t, input logic b, input logic d);
      return {t, b, d};
   endfunction
   // Expected outputs k cycles after the PLAY_START edge.
   function automatic logic [9:0] exp_song(input int k);
      if (k >= 256) return e(8'h70, 1'b0, k == 256);
      return e((k % 16) < 12 ? song[k / 16] : 8'h70, 1'b1, 1'b0);
   endfunction
   task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got tone=%h busy=%b done=%b, want tone=%h busy=%b done=%b",
                  tag, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
      end
   endtask
   task automatic step(input string tag, input logic v, input logic b, input logic [7:0] c,
                       input logic s, input logic p, input logic [9:0] ex);
      @(negedge clk);
      kv = v; kb = b; kc = c; ps = s; pp = p;
      tq.push_back(tag);
      vq.push_back(ex);
   endtask
   task automatic drain();
      @(posedge clk);
      #3;
      chk("drain", 10'(vq.size()), 10'd0);
   endtask
   always @(posedge clk) begin
      #2;
      if (vq.size() != 0) chk(tq.pop_front(), {tone, busy, done}, vq.pop_front());
   end
   initial begin
      #1 rst_n = 1'b0;
      #2 chk("reset", {tone, busy, done}, e(8'h70, 0, 0));
      @(negedge clk) rst_n = 1'b1;
      step("make73", 1, 0, 8'h73, 0, 0, e(8'h73, 0, 0));
      step("hold73", 0, 0, 8'h00, 0, 0, e(8'h73, 0, 0));
      step("brk73", 1, 1, 8'h73, 0, 0, e(8'h70, 0, 0));
      step("idle", 0, 0, 8'h00, 0, 0, e(8'h70, 0, 0));
      step("bad_idle", 1, 0, 8'h12, 0, 0, e(8'h70, 0, 0));
      step("make69", 1, 0, 8'h69, 0, 0, e(8'h69, 0, 0));
      step("bad_live", 1, 0, 8'h12, 0, 0, e(8'h69, 0, 0));
      step("brk72_ign", 1, 1, 8'h72, 0, 0, e(8'h69, 0, 0));
      step("start_live", 0, 0, 8'h00, 1, 0, e(8'h69, 0, 0));
      step("hold_live", 0, 0, 8'h00, 0, 0, e(8'h69, 0, 0));
      step("make7D", 1, 0, 8'h7D, 0, 0, e(8'h7D, 0, 0));
      step("brk69_ign", 1, 1, 8'h69, 0, 0, e(8'h7D, 0, 0));
      step("brk7D", 1, 1, 8'h7D, 0, 0, e(8'h70, 0, 0));
      step("song_start", 0, 0, 8'h00, 1, 0, exp_song(0));
      for (int k = 1; k <= 258; k++) step("song", 0, 0, 8'h00, k == 20, 0, exp_song(k));
      step("s2_start", 0, 0, 8'h00, 1, 0, exp_song(0));
      for (int k = 1; k < 256; k++) step("s2", 0, 0, 8'h00, 0, 0, exp_song(k));
      step("stop_at_end", 0, 0, 8'h00, 0, 1, e(8'h70, 0, 0));
      repeat (2) step("after_stop", 0, 0, 8'h00, 0, 0, e(8'h70, 0, 0));
      step("s3_start", 0, 0, 8'h00, 1, 0, exp_song(0));
      for (int k = 1; k < 5; k++) step("s3", 0, 0, 8'h00, 0, 0, exp_song(k));
      step("stop", 0, 0, 8'h00, 0, 1, e(8'h70, 0, 0));
      repeat (16) step("stopped", 0, 0, 8'h00, 0, 0, e(8'h70, 0, 0));
      step("s4_start", 0, 0, 8'h00, 1, 0, exp_song(0));
      for (int k = 1; k < 30; k++) step("s4", 0, 0, 8'h00, 0, 0, exp_song(k));
      step("stop_and_make", 1, 0, 8'h69, 0, 1, e(8'h69, 0, 0));
      repeat (3) step("live69", 0, 0, 8'h00, 0, 0, e(8'h69, 0, 0));
      step("brk69", 1, 1, 8'h69, 0, 0, e(8'h70, 0, 0));
      step("s5_start", 0, 0, 8'h00, 1, 0, exp_song(0));
      for (int k = 1; k < 45; k++) step("s5", 0, 0, 8'h00, 0, 0, exp_song(k));
      step("abort7A", 1, 0, 8'h7A, 0, 0, e(8'h7A, 0, 0));
      repeat (20) step("live7A", 0, 0, 8'h00, 0, 0, e(8'h7A, 0, 0));
      step("brk7A", 1, 1, 8'h7A, 0, 0, e(8'h70, 0, 0));
      step("s6_start", 0, 0, 8'h00, 1, 0, exp_song(0));
      for (int k = 1; k < 70; k++) step("s6", 0, 0, 8'h00, 0, 0, exp_song(k));
      drain();
      rst_n = 1'b0;
      #1 chk("async_rst", {tone, busy, done}, e(8'h70, 0, 0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) step("post_rst", 0, 0, 8'h00, 0, 0, e(8'h70, 0, 0));
      drain();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
